// File: rtl/ws2812_frame_scheduler.sv
// WS2812 frame sequencer: fetches LED_NUM pixels from a synchronous RAM, hands each to the RZ encoder,
// then holds the line idle for the latch gap. Optional brightness scaling stage under WS2812_BRIGHT_EN.
module ws2812_frame_scheduler #(
  parameter int LED_NUM     = 64,
  parameter int ADDR_W      = 6,
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int RESET_US    = 300,
  parameter int DONE_TMO    = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  output logic              busy,
  output logic              frame_done,
  output logic              err,
  output logic              pix_rd,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [23:0]       pix_data,
  output logic              tx_en,
  output logic [23:0]       RGB,
  input  logic              tx_done
`ifdef WS2812_BRIGHT_EN
  ,
  input  logic [7:0]        bright
`endif
);

  localparam int LATCH_CYC = CLK_FREQ_HZ / 1_000_000 * RESET_US;
  localparam int TMO_W     = (DONE_TMO > 1) ? $clog2(DONE_TMO) : 1;
  localparam int LAT_W     = (LATCH_CYC > 1) ? $clog2(LATCH_CYC) : 1;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LED_NUM - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(DONE_TMO - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(LATCH_CYC - 1);

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] FETCH  = 4'd1;
  localparam logic [3:0] RDWAIT = 4'd2;
  localparam logic [3:0] SEND   = 4'd3;
  localparam logic [3:0] WAIT   = 4'd4;
  localparam logic [3:0] LATCH  = 4'd5;
  localparam logic [3:0] DONE   = 4'd6;
  localparam logic [3:0] ERR    = 4'd7;
`ifdef WS2812_BRIGHT_EN
  localparam logic [3:0] SCALE  = 4'd8;

  function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] p;
    p = {8'd0, c} * ({8'd0, b} + 16'd1);
    return p[15:8];
  endfunction
`endif

  logic [3:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [TMO_W-1:0]  tmo;
  logic [LAT_W-1:0]  lat;

  assign busy       = (state != IDLE);
  assign pix_rd     = (state == FETCH);
  assign pix_addr   = idx;
  assign tx_en      = (state == SEND);
  assign frame_done = (state == DONE);
  assign err        = (state == ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      tmo   <= '0;
      lat   <= '0;
      RGB   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_start) begin
            state <= FETCH;
            idx   <= '0;
          end
        end
        FETCH: begin
          tmo   <= '0;
          state <= RDWAIT;
        end
        RDWAIT: begin
          RGB <= pix_data;
`ifdef WS2812_BRIGHT_EN
          state <= SCALE;
`else
          state <= SEND;
`endif
        end
`ifdef WS2812_BRIGHT_EN
        SCALE: begin
          RGB   <= {scale8(RGB[23:16], bright), scale8(RGB[15:8], bright), scale8(RGB[7:0], bright)};
          state <= SEND;
        end
`endif
        SEND: begin
          // tmo counts cycles elapsed since tx_en, so the abort lands DONE_TMO cycles after it
          tmo   <= tmo + TMO_W'(1);
          state <= WAIT;
        end
        WAIT: begin
          if (tx_done) begin
            if (idx == LAST_IDX) begin
              lat   <= '0;
              state <= LATCH;
            end else begin
              idx   <= idx + ADDR_W'(1);
              state <= FETCH;
            end
          end else if (tmo == TMO_LAST) begin
            state <= ERR;
          end else begin
            tmo <= tmo + TMO_W'(1);
          end
        end
        LATCH: begin
          if (lat == LAT_LAST) state <= DONE;
          else                 lat   <= lat + LAT_W'(1);
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
